// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and helpers for the BCD counter-bank sequencer
package bcd_pkg;

    localparam int NDIGITS = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRESET = 2'd1,
        S_MANUAL = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

    function automatic logic all_bcd(input logic [4*NDIGITS-1:0] val);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            ok = ok & is_bcd(val[4*i +: 4]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - count-rate prescaler; holds while run is low, one-cycle tick at DIV-1
module tick_gen #(
    parameter int DIV   = 100_000_000,
    parameter int DIV_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && (cnt_q == DIV_W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (run_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_ctrl.sv
// rtl/bcd_ctrl.sv - sequencer driving en/upd/load/bitSW/digitSW of the 8-digit BCD counter bank
module bcd_ctrl
    import bcd_pkg::*;
#(
    parameter int DIV   = 100_000_000,
    parameter int DIV_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_sw,
    input  logic        dir_sw,
    input  logic        man_load,
    input  logic [2:0]  man_idx,
    input  logic [3:0]  man_digit,
    input  logic        preset_req,
    input  logic [31:0] preset_val,
    output logic        en,
    output logic        upd,
    output logic        load,
    output logic [2:0]  bitSW,
    output logic [3:0]  digitSW,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      state_q, state_d;
    logic [31:0] preset_q, preset_d;
    logic        man_prev_q;
    logic        upd_q;
    logic        load_q, load_d;
    logic [2:0]  bitSW_q, bitSW_d;
    logic [3:0]  digitSW_q, digitSW_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        man_edge, preset_go, man_go, run;

    assign man_edge = man_load && !man_prev_q;

    // The prescaler also freezes in the cycle a sequence is accepted, so no tick overlaps a load.
    assign run = (state_q == S_IDLE) && run_sw && !(preset_go || man_go);

    tick_gen #(.DIV(DIV), .DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .run_i  (run),
        .tick_o (en)
    );

    always_comb begin
        state_d   = state_q;
        preset_d  = preset_q;
        load_d    = 1'b0;
        bitSW_d   = bitSW_q;
        digitSW_d = digitSW_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        preset_go = 1'b0;
        man_go    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (preset_req) begin
                    if (all_bcd(preset_val)) begin
                        preset_go = 1'b1;
                        preset_d  = preset_val >> 4;
                        state_d   = S_PRESET;
                        load_d    = 1'b1;
                        busy_d    = 1'b1;
                        bitSW_d   = 3'd0;
                        digitSW_d = preset_val[3:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (man_edge) begin
                    if (is_bcd(man_digit)) begin
                        man_go    = 1'b1;
                        state_d   = S_MANUAL;
                        load_d    = 1'b1;
                        busy_d    = 1'b1;
                        bitSW_d   = man_idx;
                        digitSW_d = man_digit;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PRESET: begin
                if (bitSW_q == 3'(NDIGITS - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    load_d    = 1'b1;
                    busy_d    = 1'b1;
                    bitSW_d   = bitSW_q + 3'd1;
                    digitSW_d = preset_q[3:0];
                    preset_d  = preset_q >> 4;
                end
            end
            S_MANUAL: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            preset_q   <= '0;
            man_prev_q <= 1'b0;
            upd_q      <= 1'b0;
            load_q     <= 1'b0;
            bitSW_q    <= '0;
            digitSW_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            preset_q   <= preset_d;
            man_prev_q <= man_load;
            upd_q      <= dir_sw;
            load_q     <= load_d;
            bitSW_q    <= bitSW_d;
            digitSW_q  <= digitSW_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign upd     = upd_q;
    assign load    = load_q;
    assign bitSW   = bitSW_q;
    assign digitSW = digitSW_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_ctrl.sv
// tb/tb_bcd_ctrl.sv - scoreboard bench for bcd_ctrl against a cycle-indexed reference model
module tb_bcd_ctrl;

    localparam int DIV = 4;
    localparam int K_LOAD = 1, K_DONE = 2, K_ERR = 3;

    typedef struct {
        int cyc;
        int kind;
        int idx;
        int dig;
    } ev_t;

    typedef struct {
        logic en;
        logic upd;
        logic busy;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_sw = 1'b0, dir_sw = 1'b0, man_load = 1'b0, preset_req = 1'b0;
    logic [2:0]  man_idx = '0;
    logic [3:0]  man_digit = '0;
    logic [31:0] preset_val = '0;
    logic        en, upd, load, busy, done, err;
    logic [2:0]  bitSW;
    logic [3:0]  digitSW;

    bcd_ctrl #(.DIV(DIV)) dut (
        .clk(clk), .rst(rst), .run_sw(run_sw), .dir_sw(dir_sw),
        .man_load(man_load), .man_idx(man_idx), .man_digit(man_digit),
        .preset_req(preset_req), .preset_val(preset_val),
        .en(en), .upd(upd), .load(load), .bitSW(bitSW), .digitSW(digitSW),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    bit mon_on = 1'b0;
    ev_t  ev_q[$];
    rec_t rec_q[$];
    int en_total = 0, load_total = 0, done_total = 0, err_total = 0;

    // reference model state, in terms of cycles rather than FSM states
    int   idle_from = 0, busy_lo = 1, busy_hi = 0, pres = 0;
    logic prev_dir = 1'b0, prev_man = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic push_ev(input int c, input int k, input int i, input int d);
        ev_t e;
        e.cyc = c; e.kind = k; e.idx = i; e.dig = d;
        ev_q.push_back(e);
    endtask

    function automatic logic bcd_word(input logic [31:0] v);
        for (int i = 0; i < 8; i++) if (((v >> (4*i)) & 32'hF) > 9) return 1'b0;
        return 1'b1;
    endfunction

    // Model one cycle with the inputs currently applied, then advance the clock.
    task automatic step();
        rec_t r;
        logic idle, accepted;
        idle = (cyc >= idle_from);
        accepted = 1'b0;
        r.busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        r.upd = prev_dir;
        if (!rst && idle) begin
            if (preset_req) begin
                if (bcd_word(preset_val)) begin
                    for (int i = 0; i < 8; i++)
                        push_ev(cyc + 1 + i, K_LOAD, i, int'((preset_val >> (4*i)) & 32'hF));
                    push_ev(cyc + 9, K_DONE, 0, 0);
                    idle_from = cyc + 10; busy_lo = cyc + 1; busy_hi = cyc + 8;
                    accepted = 1'b1;
                end else push_ev(cyc + 1, K_ERR, 0, 0);
            end else if (man_load && !prev_man) begin
                if (man_digit <= 9) begin
                    push_ev(cyc + 1, K_LOAD, int'(man_idx), int'(man_digit));
                    push_ev(cyc + 2, K_DONE, 0, 0);
                    idle_from = cyc + 3; busy_lo = cyc + 1; busy_hi = cyc + 1;
                    accepted = 1'b1;
                end else push_ev(cyc + 1, K_ERR, 0, 0);
            end
        end
        r.en = idle && run_sw && !accepted && (pres == DIV - 1);
        if (idle && run_sw && !accepted) pres = (pres + 1) % DIV;
        prev_dir = dir_sw;
        prev_man = man_load;
        if (rst) begin
            while (ev_q.size() > 0 && ev_q[$].cyc > cyc) void'(ev_q.pop_back());
            idle_from = cyc + 1;
            if (busy_hi > cyc) busy_hi = cyc;
            pres = 0; prev_dir = 1'b0; prev_man = 1'b0;
        end
        rec_q.push_back(r);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            rec_t r;
            ev_t  e;
            int   k;
            if (rec_q.size() > 0) begin
                r = rec_q.pop_front();
                chk("en", 32'(en), 32'(r.en));
                chk("upd", 32'(upd), 32'(r.upd));
                chk("busy", 32'(busy), 32'(r.busy));
            end
            en_total += int'(en);
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                e = ev_q.pop_front();
                chk("missed_event", 0, 32'(e.kind));
            end
            if (int'(load) + int'(done) + int'(err) > 1)
                chk("single_event", 32'(int'(load) + int'(done) + int'(err)), 1);
            k = load ? K_LOAD : done ? K_DONE : err ? K_ERR : 0;
            load_total += int'(load);
            done_total += int'(done);
            err_total  += int'(err);
            if (k != 0) begin
                if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                    e = ev_q.pop_front();
                    chk("event_kind", 32'(k), 32'(e.kind));
                    if (k == K_LOAD) begin
                        chk("bitSW", 32'(bitSW), 32'(e.idx));
                        chk("digitSW", 32'(digitSW), 32'(e.dig));
                    end
                end else begin
                    chk("unexpected_event", 32'(k), 0);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, 32'(en), 0);
        chk({tag, "_upd"}, 32'(upd), 0);
        chk({tag, "_load"}, 32'(load), 0);
        chk({tag, "_bitSW"}, 32'(bitSW), 0);
        chk({tag, "_digitSW"}, 32'(digitSW), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        int e0, l0, d0, r0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all_zero("reset");
        mon_on = 1'b1;

        // tick: 20 running cycles give 5 ticks; stopped gives none
        e0 = en_total;
        run_sw = 1'b1;
        idle_steps(20);
        chk("tick_count_run", 32'(en_total - e0), 5);
        e0 = en_total;
        run_sw = 1'b0;
        idle_steps(10);
        chk("tick_count_stop", 32'(en_total - e0), 0);

        // valid preset while running
        run_sw = 1'b1;
        l0 = load_total; d0 = done_total; e0 = en_total;
        preset_val = 32'h8765_4321; preset_req = 1'b1; step(); preset_req = 1'b0;
        idle_steps(9);
        chk("preset_loads", 32'(load_total - l0), 8);
        chk("preset_done", 32'(done_total - d0), 1);
        chk("preset_no_en", 32'(en_total - e0), 0);
        idle_steps(3);
        run_sw = 1'b0;

        // preset with a non-BCD nibble
        l0 = load_total; r0 = err_total;
        preset_val = 32'h0000_00A0; preset_req = 1'b1; step(); preset_req = 1'b0;
        idle_steps(4);
        chk("bad_preset_err", 32'(err_total - r0), 1);
        chk("bad_preset_loads", 32'(load_total - l0), 0);

        // manual load held high for 10 cycles
        l0 = load_total; d0 = done_total;
        man_idx = 3'd5; man_digit = 4'd9; man_load = 1'b1;
        idle_steps(10);
        man_load = 1'b0;
        idle_steps(3);
        chk("manual_loads", 32'(load_total - l0), 1);
        chk("manual_done", 32'(done_total - d0), 1);

        // preset and manual edge together, then preset during busy
        l0 = load_total; d0 = done_total;
        preset_val = 32'h1234_5678; preset_req = 1'b1; man_load = 1'b1; man_idx = 3'd2;
        step();
        preset_req = 1'b0; man_load = 1'b0;
        idle_steps(2);
        preset_val = 32'h9999_9999; preset_req = 1'b1; step(); preset_req = 1'b0;
        idle_steps(10);
        chk("collide_loads", 32'(load_total - l0), 8);
        chk("collide_done", 32'(done_total - d0), 1);

        // reset in the middle of a preset
        d0 = done_total;
        dir_sw = 1'b1;
        preset_val = 32'h0102_0304; preset_req = 1'b1; step(); preset_req = 1'b0;
        idle_steps(3);
        rst = 1'b1; step(); rst = 1'b0;
        dir_sw = 1'b0;
        chk_all_zero("midreset");
        idle_steps(12);
        chk("midreset_no_done", 32'(done_total - d0), 0);

        // randomized traffic
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(9, 0) == 0) run_sw = ~run_sw;
            dir_sw = 1'($urandom_range(1, 0));
            rst = ($urandom_range(149, 0) == 0);
            preset_req = !rst && ($urandom_range(14, 0) == 0);
            if (preset_req) begin
                if ($urandom_range(1, 0) == 1) begin
                    for (int d = 0; d < 8; d++) preset_val[4*d +: 4] = 4'($urandom_range(9, 0));
                end else begin
                    preset_val = $urandom;
                end
            end
            if ($urandom_range(4, 0) == 0) man_load = ~man_load;
            if (rst) man_load = 1'b0;
            man_idx = 3'($urandom_range(7, 0));
            man_digit = 4'($urandom_range(15, 0));
            step();
        end
        rst = 1'b0; preset_req = 1'b0; man_load = 1'b0;
        idle_steps(15);
        chk("events_drained", 32'(ev_q.size()), 0);

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
